byte_word_rr_scheduler: RTL
===========================

// Module: byte_word_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing the 8b->32b word packer among N_SRC byte sources.
//  Grants one source per 32-bit word and drains exactly 4 bytes from it back-to-back.
//  The packer therefore sees contiguous valid_in bursts of 4, never interleaved or gapped.
//  Sits between the per-lane byte FIFOs (show-ahead) and the packer's valid_in/Data_in.
// PARAMETERS
//  N_SRC   4   number of byte sources (2..8)
//  SRC_W   2   width of source id, = $clog2(N_SRC)
// PORTS
//  clk_4f       in   1          byte-rate clock, single clock domain
//  reset        in   1          asynchronous, active-low reset
//  enable       in   1          1 = new grants allowed; 0 = finish current word, then idle
//  req          in   N_SRC      req[i]=1: source i holds >=4 bytes, head byte on src_data
//  src_data     in   8*N_SRC    byte i at [8i+7:8i], show-ahead (valid same cycle as req)
//  pop          out  N_SRC      one-hot combinational read strobe to granted source FIFO
//  valid_out    out  1          registered; drives packer valid_in
//  Data_out     out  8          registered; drives packer Data_in
//  src_id       out  SRC_W      registered; source of current Data_out byte
//  word_last    out  1          registered; 1 on 4th byte of a word
//  busy         out  1          1 while a word is in progress (state BURST)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, beat=0, rr_ptr=0, pop=0, valid_out=0, Data_out=8'h00,
//   src_id=0, word_last=0, busy=0. Reset mid-word abandons the word; no resume.
//  States: IDLE, BURST. beat: 2-bit counter of bytes issued in current word.
//  Arbitration: among req[i], first i at/after rr_ptr (wrapping mod N_SRC) wins.
//   On grant to i, rr_ptr <= (i+1) mod N_SRC. Grant fixed for all 4 beats.
//  IDLE: if enable && |req -> grant g, pop[g]=1 this cycle, beat<=1, go BURST.
//   Else pop=0, stay IDLE.
//  BURST: pop[g]=1 every cycle; beat increments. On beat==3 (4th pop):
//   if enable && |req -> re-arbitrate same cycle, new grant, beat<=0-> next pop; no bubble.
//   else -> IDLE.
//  req of the granted source is ignored during BURST (source guaranteed >=4 bytes at grant).
//  Output pipeline: 1-cycle latency. Cycle after pop[g]: valid_out=1, Data_out=byte popped,
//   src_id=g, word_last=1 on 4th byte. Cycles with no pop: valid_out=0, Data_out holds.
//  enable falling mid-word: current word completes all 4 bytes; no new grant.
//  Single requester: re-granted back-to-back indefinitely (continuous valid_out).
//  All requesters idle: valid_out=0 after last word; rr_ptr retained.
//  N_SRC not power of 2: rr_ptr wraps at N_SRC-1 -> 0; ids >= N_SRC never produced.
// CONFIGURATION
//  RR_WORD_CNT_EN defined: adds output word_cnt [16*N_SRC-1:0]; counter i increments on
//   each word_last with src_id==i, saturates at 16'hFFFF, cleared by reset only.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package (word8b32b_pkg): SRC_W derivation function, BYTES_PER_WORD=4,
//   state enum {IDLE, BURST}, byte/word width constants shared with the packer.
//  One sub-module: rr_arbiter (req, rr_ptr -> one-hot grant + encoded id), combinational.
//  Top holds FSM, beat counter, rr_ptr, output registers, optional counters.
// TESTING
//  1. Reset release, req=0: valid_out=0, pop=0, busy=0 for 20 cycles.
//  2. req=4'b0001, bytes 11,22,33,44: pop[0] 4 cycles; Data_out 11,22,33,44, src_id=0,
//     word_last on 44; packer outputs 32'h11223344.
//  3. req=4'b1111 continuous: grant order 0,1,2,3,0; 16 back-to-back valid_out, no gaps.
//  4. req=4'b1010, rr_ptr=0: grants 1 then 3 then 1; src_id matches per word.
//  5. enable dropped after beat 1: remaining 3 bytes still issued, then IDLE, valid_out=0.
//  6. reset asserted after beat 2: outputs 0 immediately (async); after release, new word
//     starts at src 0 with beat 0; RR_WORD_CNT_EN build: word_cnt all 0.

Source files
------------

// File: rtl/word8b32b_pkg.sv
// ---------------------------------------------------------------------------
// word8b32b_pkg
// Shared definitions for the byte-to-word path: byte and word widths, bytes
// per packed word, the scheduler state encoding and the source-id width
// derivation used by the round-robin scheduler and its arbiter.
// ---------------------------------------------------------------------------
package word8b32b_pkg;

    localparam int BYTE_W         = 32'sd8;
    localparam int WORD_W         = 32'sd32;
    localparam int BYTES_PER_WORD = 32'sd4;
    localparam int BEAT_W         = 32'sd2;
    localparam int CNT_W          = 32'sd16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Source-id width for 2..8 sources; never narrower than one bit.
    function automatic int src_w_f(input int n_src);
        if (n_src > 32'sd4) begin
            return 32'sd3;
        end else if (n_src > 32'sd2) begin
            return 32'sd2;
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/byte_word_rr_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requesting source at or after
// rr_ptr_i (wrapping at N_SRC) wins.
// Ports:
//   req_i     [N_SRC-1:0]  request vector
//   rr_ptr_i  [SRC_W-1:0]  highest-priority source this cycle (< N_SRC)
//   gnt_o     [N_SRC-1:0]  one-hot grant, all zero when nobody requests
//   gnt_id_o  [SRC_W-1:0]  encoded id of the winner
//   gnt_vld_o              some source requested
// ---------------------------------------------------------------------------
module rr_arbiter
    import word8b32b_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = src_w_f(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [SRC_W-1:0] rr_ptr_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [SRC_W-1:0] gnt_id_o,
    output logic             gnt_vld_o
);

    logic [SRC_W:0]   sum_s;
    logic [SRC_W-1:0] idx_s;
    logic [SRC_W-1:0] id_s;
    logic             vld_s;

    // Scan sources in priority order starting at the pointer; the extra
    // sum bit lets the wrap work for source counts that are not powers of 2.
    always_comb begin
        sum_s = '0;
        idx_s = '0;
        id_s  = '0;
        vld_s = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            sum_s = {1'b0, rr_ptr_i} + (SRC_W+1)'(k);
            if (sum_s >= (SRC_W+1)'(N_SRC)) begin
                idx_s = SRC_W'(sum_s - (SRC_W+1)'(N_SRC));
            end else begin
                idx_s = sum_s[SRC_W-1:0];
            end
            if (!vld_s && req_i[idx_s]) begin
                vld_s = 1'b1;
                id_s  = idx_s;
            end else begin
                vld_s = vld_s;
            end
        end
    end

    // Expand the winner into the one-hot grant.
    always_comb begin
        if (vld_s) begin
            gnt_o = N_SRC'(1'b1) << id_s;
        end else begin
            gnt_o = '0;
        end
    end

    assign gnt_id_o  = id_s;
    assign gnt_vld_o = vld_s;

endmodule

// File: rtl/byte_word_rr_scheduler.sv
// ---------------------------------------------------------------------------
// byte_word_rr_scheduler
// Shares the 8b->32b word packer among N_SRC show-ahead byte FIFOs. One source
// is granted per word and exactly four bytes are drained from it back to back,
// so the packer only ever sees gap-free, non-interleaved bursts of four.
// Re-arbitration happens on the fourth pop, so consecutive words have no bubble.
//
// Ports:
//   clk_4f     in   byte-rate clock
//   reset      in   asynchronous active-low reset
//   enable     in   1 allows new grants; 0 lets the current word finish, then idle
//   req        in   [N_SRC]   source i holds at least four bytes
//   src_data   in   [8*N_SRC] head byte of source i at [8i+7:8i]
//   pop        out  [N_SRC]   combinational one-hot read strobe
//   valid_out  out  registered byte valid to the packer
//   Data_out   out  [8] registered byte to the packer (holds when idle)
//   src_id     out  [SRC_W] registered source of Data_out
//   word_last  out  registered, marks the fourth byte of a word
//   busy       out  a word is in progress
//   word_cnt   out  [16*N_SRC] saturating per-source word counters
//                   (present only when RR_WORD_CNT_EN is defined)
//
// Build option: RR_WORD_CNT_EN adds the word_cnt port and its counters.
// ---------------------------------------------------------------------------
module byte_word_rr_scheduler
    import word8b32b_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = src_w_f(N_SRC)
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_SRC-1:0]        req,
    input  logic [BYTE_W*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]        pop,
    output logic                    valid_out,
    output logic [BYTE_W-1:0]       Data_out,
    output logic [SRC_W-1:0]        src_id,
    output logic                    word_last,
    output logic                    busy
`ifdef RR_WORD_CNT_EN
    ,
    output logic [CNT_W*N_SRC-1:0]  word_cnt
`endif
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  gnt_q, gnt_d;

    logic              valid_q;
    logic [BYTE_W-1:0] data_q;
    logic [SRC_W-1:0]  src_id_q;
    logic              word_last_q;

    logic [N_SRC-1:0]  arb_gnt_s;
    logic [SRC_W-1:0]  arb_id_s;
    logic              arb_vld_s;
    logic [SRC_W-1:0]  rr_next_s;
    logic [SRC_W:0]    rr_sum_s;

    logic              pop_vld_s;
    logic [SRC_W-1:0]  pop_id_s;
    logic [N_SRC-1:0]  pop_vec_s;
    logic              last_s;
    logic [BYTE_W-1:0] pop_byte_s;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_arb (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (arb_gnt_s),
        .gnt_id_o  (arb_id_s),
        .gnt_vld_o (arb_vld_s)
    );

    // Pointer for the next arbitration: one past the winner, wrapping at N_SRC.
    always_comb begin
        rr_sum_s = {1'b0, arb_id_s} + {{SRC_W{1'b0}}, 1'b1};
        if (rr_sum_s >= (SRC_W+1)'(N_SRC)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = rr_sum_s[SRC_W-1:0];
        end
    end

    // Next-state, beat counting and pop generation.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        pop_vld_s = 1'b0;
        pop_id_s  = gnt_q;
        pop_vec_s = '0;
        last_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && arb_vld_s) begin
                    // First byte is popped in the grant cycle itself.
                    pop_vld_s = 1'b1;
                    pop_id_s  = arb_id_s;
                    pop_vec_s = arb_gnt_s;
                    gnt_d     = arb_id_s;
                    rr_ptr_d  = rr_next_s;
                    beat_d    = 2'd1;
                    state_d   = BURST;
                end else begin
                    state_d   = IDLE;
                end
            end
            BURST: begin
                // The granted source's req is deliberately not consulted here.
                pop_vld_s = 1'b1;
                pop_id_s  = gnt_q;
                pop_vec_s = N_SRC'(1'b1) << gnt_q;
                if (beat_q == LAST_BEAT) begin
                    last_s = 1'b1;
                    if (enable && arb_vld_s) begin
                        // Next word starts on the following cycle at beat 0.
                        gnt_d    = arb_id_s;
                        rr_ptr_d = rr_next_s;
                        beat_d   = 2'd0;
                    end else begin
                        state_d  = IDLE;
                        beat_d   = 2'd0;
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Select the head byte of the source being popped.
    always_comb begin
        pop_byte_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pop_id_s == SRC_W'(i)) begin
                pop_byte_s = src_data[BYTE_W*i +: BYTE_W];
            end else begin
                pop_byte_s = pop_byte_s;
            end
        end
    end

    // Read strobe is forced low while reset is held.
    always_comb begin
        if (!reset) begin
            pop = '0;
        end else begin
            pop = pop_vec_s;
        end
    end

    // Control state: FSM, beat counter, arbitration pointer and held grant.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

    // One-cycle output stage toward the packer; data and id hold when idle.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            src_id_q    <= '0;
            word_last_q <= 1'b0;
        end else begin
            valid_q     <= pop_vld_s;
            word_last_q <= last_s;
            if (pop_vld_s) begin
                data_q   <= pop_byte_s;
                src_id_q <= pop_id_s;
            end else begin
                data_q   <= data_q;
                src_id_q <= src_id_q;
            end
        end
    end

    assign valid_out = valid_q;
    assign Data_out  = data_q;
    assign src_id    = src_id_q;
    assign word_last = word_last_q;
    assign busy      = (state_q == BURST);

`ifdef RR_WORD_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    logic [CNT_W-1:0] cnt_q [N_SRC];

    // Per-source completed-word counters, saturating, cleared only by reset.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (valid_q && word_last_q && (src_id_q == SRC_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cnt_out
        assign word_cnt[CNT_W*gi +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule
